// File: rtl/adder_pkg.sv
// pa_adder: constants shared with the adder datapath
package pa_adder;
  localparam logic [6:0] RV_C = 7'h55;
endpackage

// File: rtl/adder_scheduler_pkg.sv
// pa_adder_sched: types and widths for the shared-adder scheduler
package pa_adder_sched;
  typedef enum logic {INIT, RUN} state_e;
  localparam int OP_W = 4;
  localparam int RES_W = 7;
  localparam int CNT_W = 4;
endpackage

// File: rtl/adder.sv
// adder: registered 4+4 bit adder with synchronous reset to RV_C
module adder
  import pa_adder::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [6:0] c
);
  always_ff @(posedge clk)
    if (rst) c <= RV_C;
    else if (valid) c <= 7'(a) + 7'(b);
endmodule

// File: rtl/adder_scheduler_rr_arbiter.sv
// rr_arbiter: cyclic first-eligible-at-or-after-pointer one-hot grant
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         eligible,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant
);
  logic done;
  always_comb begin
    grant = '0;
    done = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!done && eligible[(int'(ptr) + k) % N]) begin
        grant[(int'(ptr) + k) % N] = 1'b1;
        done = 1'b1;
      end
    end
  end
endmodule

// File: rtl/adder_scheduler.sv
// adder_scheduler: round-robin sharing of one adder among NUM_REQ requesters
module adder_scheduler
  import pa_adder_sched::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [OP_W*NUM_REQ-1:0]  req_a,
  input  logic [OP_W*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [RES_W*NUM_REQ-1:0] rsp_c,
  output logic [OP_W-1:0]          add_a,
  output logic [OP_W-1:0]          add_b,
  output logic                     add_valid,
  output logic                     add_reset,
  input  logic [RES_W-1:0]         add_c,
  output logic                     busy
);
  localparam int IW = $clog2(NUM_REQ);
  state_e state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0] ptr, infl_id, gid;
  logic infl_v;
  logic [RES_W-1:0] slot [NUM_REQ];
  logic [NUM_REQ-1:0] eligible, grant;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.eligible(eligible), .ptr(ptr), .grant(grant));
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_REQ; i++)
      eligible[i] = state == RUN && req_valid[i] && !rsp_valid[i] && !(infl_v && infl_id == IW'(i));
  end
  always_comb begin
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gid = IW'(i);
  end
  assign req_ready = grant;
  assign add_valid = |grant;
  assign add_a = add_valid ? req_a[gid*OP_W +: OP_W] : '0;
  assign add_b = add_valid ? req_b[gid*OP_W +: OP_W] : '0;
  assign add_reset = state == INIT;
  assign busy = infl_v | (|rsp_valid);
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_c[i*RES_W +: RES_W] = slot[i];
  end
  // capture targets the op issued last cycle; its slot was empty at grant, so it never races a drain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= INIT;
      cnt <= '0;
      ptr <= '0;
      infl_v <= 1'b0;
      infl_id <= '0;
      rsp_valid <= '0;
      for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
    end else begin
      if (state == INIT) begin
        cnt <= cnt + 1'b1;
        if (cnt == CNT_W'(INIT_CYCLES - 1)) state <= RUN;
      end
      infl_v <= add_valid;
      if (add_valid) begin
        infl_id <= gid;
        ptr <= gid == IW'(NUM_REQ - 1) ? '0 : gid + 1'b1;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (infl_v && infl_id == IW'(i)) begin
          slot[i] <= add_c;
          rsp_valid[i] <= 1'b1;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          slot[i] <= '0;
          rsp_valid[i] <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_adder_scheduler.sv
// tb_adder_scheduler: directed and random checks against a cycle-level behavioural model
module tb_adder_scheduler;
  localparam int N = 4;
  localparam int IC = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] req_valid = '0, rsp_ready = '0, req_ready, rsp_valid;
  logic [4*N-1:0] req_a = '0, req_b = '0;
  logic [7*N-1:0] rsp_c;
  logic [3:0] add_a, add_b;
  logic add_valid, add_reset, busy;
  logic [6:0] add_c;
  int vectors = 0, miscompares = 0;
  bit m_run, m_pv;
  int m_left, m_ptr, m_pid, m_psum;
  bit m_full [N];
  int m_val [N];
  always #5 clk = ~clk;
  adder_scheduler #(.NUM_REQ(N), .INIT_CYCLES(IC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_c(rsp_c), .add_a(add_a), .add_b(add_b), .add_valid(add_valid),
    .add_reset(add_reset), .add_c(add_c), .busy(busy)
  );
  adder u_add (.clk(clk), .rst(add_reset), .valid(add_valid), .a(add_a), .b(add_b), .c(add_c));
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_left = IC; m_ptr = 0; m_pv = 0;
    for (int i = 0; i < N; i++) begin m_full[i] = 0; m_val[i] = 0; end
  endtask
  function automatic int exp_grant();
    if (!m_run) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i] && !m_full[i] && !(m_pv && m_pid == i)) return i;
    end
    return -1;
  endfunction
  task automatic tick();
    int g;
    logic [N-1:0] er, ev;
    logic [7*N-1:0] ec, mask;
    logic [3:0] ea, eb;
    bit any;
    #1;
    g = exp_grant();
    er = '0; ea = '0; eb = '0; ev = '0; ec = '0; mask = '0; any = m_pv;
    if (g >= 0) begin er[g] = 1'b1; ea = req_a[g*4 +: 4]; eb = req_b[g*4 +: 4]; end
    for (int i = 0; i < N; i++)
      if (m_full[i]) begin ev[i] = 1'b1; ec[i*7 +: 7] = 7'(m_val[i]); mask[i*7 +: 7] = '1; any = 1; end
    check("req_ready", 32'(req_ready), 32'(er));
    check("add_valid", 32'(add_valid), 32'(g >= 0));
    check("add_a", 32'(add_a), 32'(ea));
    check("add_b", 32'(add_b), 32'(eb));
    check("add_reset", 32'(add_reset), 32'(!m_run));
    check("rsp_valid", 32'(rsp_valid), 32'(ev));
    check("rsp_c", 32'(rsp_c & mask), 32'(ec));
    check("busy", 32'(busy), 32'(any));
    @(posedge clk);
    if (reset) begin
      if (!m_run) begin m_left--; if (m_left == 0) m_run = 1; end
      for (int i = 0; i < N; i++) if (m_full[i] && rsp_ready[i]) m_full[i] = 0;
      if (m_pv) begin m_full[m_pid] = 1; m_val[m_pid] = m_psum; end
      m_pv = g >= 0;
      if (g >= 0) begin
        m_pid = g;
        m_psum = int'(req_a[g*4 +: 4]) + int'(req_b[g*4 +: 4]);
        m_ptr = (g + 1) % N;
      end
    end
    @(negedge clk);
  endtask
  task automatic rand_ops();
    req_a = 16'($urandom);
    req_b = 16'($urandom);
  endtask
  initial begin
    model_reset();
    repeat (3) tick();
    @(negedge clk);
    reset = 1'b1; req_valid = '1; rsp_ready = '1; rand_ops();
    repeat (3) tick();
    req_valid = '0;
    repeat (4) tick();
    req_valid = 4'b0001; req_a = 16'h0009; req_b = 16'h0007; rsp_ready = '0;
    tick();
    req_valid = '0;
    repeat (12) tick();
    check("single_sum", 32'(rsp_c[6:0]), 32'd16);
    rsp_ready = '1;
    repeat (2) tick();
    req_valid = '1; req_a = 16'hF503; req_b = 16'hF204;
    repeat (16) tick();
    rsp_ready = 4'b1011;
    repeat (12) begin rand_ops(); tick(); end
    rsp_ready = '1;
    repeat (6) begin rand_ops(); tick(); end
    req_valid = '0;
    repeat (4) tick();
    req_valid = 4'b0100; rand_ops();
    tick();
    req_valid = '0;
    reset = 1'b0; model_reset();
    repeat (3) tick();
    reset = 1'b1;
    repeat (5) tick();
    req_valid = 4'b0100; rand_ops();
    tick();
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1001;
    tick();
    req_valid = '0;
    repeat (3) tick();
    repeat (300) begin
      req_valid = 4'($urandom);
      rsp_ready = 4'($urandom);
      rand_ops();
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
